// File: rtl/lspc_pkg.sv
// Shared LSPC definitions: timer mode bit positions, register offsets and the
// control bundle passed from the timer register block to the counter.
package lspc_pkg;

  localparam int MODE_IRQ_EN      = 4;
  localparam int MODE_RELOAD_LO   = 5;
  localparam int MODE_RELOAD_VBL  = 6;
  localparam int MODE_RELOAD_ZERO = 7;

  localparam logic [2:0] LSPC_MODE  = 3'h3;
  localparam logic [2:0] TIMER_HI   = 3'h4;
  localparam logic [2:0] TIMER_LO   = 3'h5;
  localparam logic [2:0] TIMER_STOP = 3'h7;

  // Field order matches DIN[7:4] so a mode write is a straight cast.
  typedef struct packed {
    logic reload_zero;
    logic reload_vbl;
    logic reload_on_lo;
    logic irq_en;
  } timer_mode_t;

  // Effective (this-edge) controls seen by the counter.
  typedef struct packed {
    logic irq_en;
    logic reload_vbl;
    logic reload_zero;
    logic stop_en;
    logic load_now;
  } timer_ctrl_t;

endpackage

// File: rtl/lspc_timer_regs.sv
// Timer reload/mode/stop registers. Outputs are the post-write values so a
// write and a counter event on the same edge see the new settings.
module lspc_timer_regs
  import lspc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             WR_MODE,
  input  logic             WR_TIMER_HI,
  input  logic             WR_TIMER_LO,
  input  logic             WR_TIMER_STOP,
  input  logic [15:0]      DIN,
  output logic [CNT_W-1:0] reload_nxt,
  output timer_ctrl_t      ctrl
);
  localparam int HI_W = CNT_W - 16;

  logic [HI_W-1:0] reload_hi;
  logic [15:0]     reload_lo;
  timer_mode_t     mode, mode_nxt;
  logic            stop_en, stop_nxt;

  always_comb begin
    reload_nxt = {(WR_TIMER_HI ? DIN[HI_W-1:0] : reload_hi),
                  (WR_TIMER_LO ? DIN : reload_lo)};
    mode_nxt   = WR_MODE ? timer_mode_t'(DIN[MODE_RELOAD_ZERO:MODE_IRQ_EN]) : mode;
    stop_nxt   = WR_TIMER_STOP ? DIN[0] : stop_en;

    ctrl             = '0;
    ctrl.irq_en      = mode_nxt.irq_en;
    ctrl.reload_vbl  = mode_nxt.reload_vbl;
    ctrl.reload_zero = mode_nxt.reload_zero;
    ctrl.stop_en     = stop_nxt;
    ctrl.load_now    = WR_TIMER_LO & mode_nxt.reload_on_lo;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      reload_hi <= '0;
      reload_lo <= '0;
      mode      <= '0;
      stop_en   <= 1'b0;
    end else begin
      reload_hi <= reload_nxt[CNT_W-1:16];
      reload_lo <= reload_nxt[15:0];
      mode      <= mode_nxt;
      stop_en   <= stop_nxt;
    end
  end

endmodule

// File: rtl/lspc_timer_sync.sv
// LSPC raster timer: pixel-enabled down-counter with reload priority mux and
// a registered one-CLK IRQ pulse on the zero event.
module lspc_timer_sync
  import lspc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             CLK_EN,
  input  logic             WR_MODE,
  input  logic             WR_TIMER_HI,
  input  logic             WR_TIMER_LO,
  input  logic             WR_TIMER_STOP,
  input  logic [15:0]      DIN,
  input  logic             VBL_START,
  input  logic             PAL_BORDER,
  output logic             TIMER_IRQ,
  output logic [CNT_W-1:0] TIMER_CNT
);
  logic [CNT_W-1:0] reload_nxt;
  timer_ctrl_t      ctrl;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             zero_evt;

  lspc_timer_regs #(.CNT_W(CNT_W)) u_regs (
    .CLK           (CLK),
    .nRESET        (nRESET),
    .WR_MODE       (WR_MODE),
    .WR_TIMER_HI   (WR_TIMER_HI),
    .WR_TIMER_LO   (WR_TIMER_LO),
    .WR_TIMER_STOP (WR_TIMER_STOP),
    .DIN           (DIN),
    .reload_nxt    (reload_nxt),
    .ctrl          (ctrl)
  );

  // LO-write reload bypasses CLK_EN; everything else waits for a pixel edge.
  always_comb begin
    cnt_nxt  = cnt;
    zero_evt = 1'b0;
    if (ctrl.load_now) begin
      cnt_nxt = reload_nxt;
    end else if (CLK_EN) begin
      if (VBL_START && ctrl.reload_vbl) begin
        cnt_nxt = reload_nxt;
      end else if (ctrl.stop_en && PAL_BORDER) begin
        cnt_nxt = cnt;
      end else if (cnt == '0) begin
        zero_evt = 1'b1;
        cnt_nxt  = ctrl.reload_zero ? reload_nxt : {CNT_W{1'b1}};
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt       <= '0;
      TIMER_IRQ <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      TIMER_IRQ <= zero_evt & ctrl.irq_en;
    end
  end

  assign TIMER_CNT = cnt;

endmodule

// File: tb/tb_lspc_timer_sync.sv
// Directed bench for lspc_timer_sync: a vector table for register/priority
// behaviour plus hand sequences for periodic IRQ, stop freeze and reset.
module tb_lspc_timer_sync;
  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        CLK_EN = 1'b0;
  logic        WR_MODE = 1'b0, WR_TIMER_HI = 1'b0, WR_TIMER_LO = 1'b0, WR_TIMER_STOP = 1'b0;
  logic [15:0] DIN = '0;
  logic        VBL_START = 1'b0, PAL_BORDER = 1'b0;
  logic        TIMER_IRQ;
  logic [31:0] TIMER_CNT;

  int checks = 0;
  int errors = 0;

  lspc_timer_sync #(.CNT_W(32)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN(CLK_EN),
    .WR_MODE(WR_MODE), .WR_TIMER_HI(WR_TIMER_HI), .WR_TIMER_LO(WR_TIMER_LO),
    .WR_TIMER_STOP(WR_TIMER_STOP), .DIN(DIN), .VBL_START(VBL_START),
    .PAL_BORDER(PAL_BORDER), .TIMER_IRQ(TIMER_IRQ), .TIMER_CNT(TIMER_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en, wm, wh, wl, ws;
    logic [15:0] din;
    logic        vbl, pal;
    logic        exp_irq;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, wm, wh, wl, ws, input logic [15:0] din,
                       input logic vbl, pal);
    CLK_EN = en; WR_MODE = wm; WR_TIMER_HI = wh; WR_TIMER_LO = wl;
    WR_TIMER_STOP = ws; DIN = din; VBL_START = vbl; PAL_BORDER = pal;
  endtask

  // Inputs are applied 1 time unit after an edge, so one step = one CLK edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    nRESET = 1'b0;
    step(); step();
    nRESET = 1'b1;
    step();
  endtask

  initial begin
    // en wm wh wl ws din vbl pal | irq cnt
    vec.push_back('{0,1,0,0,0,16'h0020,0,0, 0,32'h0000_0000});
    vec.push_back('{0,0,1,0,0,16'h0001,0,0, 0,32'h0000_0000});
    vec.push_back('{0,0,0,1,0,16'h0002,0,0, 0,32'h0001_0002}); // LO load with CLK_EN=0
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'h0001_0001});
    vec.push_back('{0,0,0,0,0,16'h0000,0,0, 0,32'h0001_0001});
    vec.push_back('{1,0,1,1,0,16'h0003,0,0, 0,32'h0003_0003}); // HI+LO together, load beats step
    vec.push_back('{0,1,0,0,0,16'h0030,0,0, 0,32'h0003_0003});
    vec.push_back('{0,0,1,0,0,16'h0000,0,0, 0,32'h0003_0003});
    vec.push_back('{0,0,0,1,0,16'h0002,0,0, 0,32'h0000_0002});
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'h0000_0001});
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'h0000_0000});
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 1,32'hFFFF_FFFF}); // wrap, one pulse
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'hFFFF_FFFE});
    vec.push_back('{0,0,0,1,0,16'h0000,0,0, 0,32'h0000_0000});
    vec.push_back('{0,1,0,0,0,16'h0050,0,0, 0,32'h0000_0000});
    vec.push_back('{0,0,0,1,0,16'h0064,0,0, 0,32'h0000_0000}); // reload=100, no load
    vec.push_back('{1,0,0,0,0,16'h0000,1,0, 0,32'h0000_0064}); // VBL beats zero event
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'h0000_0063});
    vec.push_back('{0,1,0,0,0,16'h0030,0,0, 0,32'h0000_0063});
    vec.push_back('{0,0,0,1,0,16'h0000,0,0, 0,32'h0000_0000});
    vec.push_back('{1,1,0,0,0,16'h0000,0,0, 0,32'hFFFF_FFFF}); // irq_en cleared on zero edge
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'hFFFF_FFFE});
    vec.push_back('{0,0,0,0,1,16'h0001,0,0, 0,32'hFFFF_FFFE});
    vec.push_back('{1,0,0,0,0,16'h0000,0,1, 0,32'hFFFF_FFFE}); // stopped
    vec.push_back('{1,0,0,0,0,16'h0000,0,0, 0,32'hFFFF_FFFD});
    vec.push_back('{1,0,0,0,0,16'h0000,1,0, 0,32'hFFFF_FFFC}); // VBL ignored, reload_vbl=0

    // Reset state
    #2;
    chk("reset_cnt", TIMER_CNT, 32'h0);
    chk("reset_irq", {31'b0, TIMER_IRQ}, 32'h0);
    step();
    nRESET = 1'b1;
    step();
    chk("post_reset_cnt", TIMER_CNT, 32'h0);

    // Periodic IRQ: reload=5, irq_en+reload_on_zero, CLK_EN every 4 CLK
    drive(0, 0, 1, 0, 0, 16'h0000, 0, 0); step();
    drive(0, 0, 0, 1, 0, 16'h0005, 0, 0); step();
    drive(0, 1, 0, 0, 0, 16'h0090, 0, 0); step();
    chk("periodic_setup_cnt", TIMER_CNT, 32'h0);
    for (int c = 0; c < 96; c++) begin
      drive((c % 4) == 0, 0, 0, 0, 0, 16'h0, 0, 0);
      step();
      chk($sformatf("periodic_irq_c%0d", c), {31'b0, TIMER_IRQ},
          {31'b0, ((c % 4) == 0) && (((c / 4) % 6) == 0)});
    end
    chk("periodic_end_cnt", TIMER_CNT, 32'h0);

    // Vector table
    do_reset();
    foreach (vec[i]) begin
      drive(vec[i].en, vec[i].wm, vec[i].wh, vec[i].wl, vec[i].ws, vec[i].din,
            vec[i].vbl, vec[i].pal);
      step();
      chk($sformatf("vec%0d_cnt", i), TIMER_CNT, vec[i].exp_cnt);
      chk($sformatf("vec%0d_irq", i), {31'b0, TIMER_IRQ}, {31'b0, vec[i].exp_irq});
    end

    // Stop freeze at cnt==0 for 32 enables (stop_en still set), then resume
    drive(0, 1, 0, 0, 0, 16'h0030, 0, 0); step();
    drive(0, 0, 0, 1, 0, 16'h0000, 0, 0); step();
    chk("stop_setup_cnt", TIMER_CNT, 32'h0);
    for (int k = 0; k < 32; k++) begin
      drive(1, 0, 0, 0, 0, 16'h0, 0, 1);
      step();
      chk($sformatf("stop_cnt_%0d", k), TIMER_CNT, 32'h0);
      chk($sformatf("stop_irq_%0d", k), {31'b0, TIMER_IRQ}, 32'h0);
    end
    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    step();
    chk("resume_irq", {31'b0, TIMER_IRQ}, 32'h1);
    chk("resume_cnt", TIMER_CNT, 32'hFFFF_FFFF);

    // Reset while the pulse is on the output
    nRESET = 1'b0;
    #2;
    chk("midreset_irq", {31'b0, TIMER_IRQ}, 32'h0);
    chk("midreset_cnt", TIMER_CNT, 32'h0);
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    step(); step();
    nRESET = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
      step();
      chk($sformatf("after_reset_irq_%0d", k), {31'b0, TIMER_IRQ}, 32'h0);
    end
    chk("after_reset_cnt", TIMER_CNT, 32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
